// File: rtl/io_ring_pkg.sv
// IO-ring power sequencer shared types and defaults.
// Optional drop counter is enabled by defining IO_SEQ_STATUS_EN.
package io_ring_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DEBOUNCE,
        ST_RELEASE,
        ST_ON,
        ST_DRAIN
    } io_state_e;

    localparam int DEBOUNCE_CYC_DEF = 64;
    localparam int HOLD_CYC_DEF     = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
// Used for the VDDIO power-good input.
module io_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_ring_pwr_seq.sv
// IO pad-ring power sequencer: debounce, release, on, drain.
// Define IO_SEQ_STATUS_EN to add the DROP_CNT_O power-good drop counter.
module io_ring_pwr_seq
    import io_ring_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int HOLD_CYC     = HOLD_CYC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PG_VDDIO_I,
    input  logic       EN_REQ_I,
    output logic       EN_ACK_O,
    output logic       RET_O,
    output logic       OE_O,
    output logic       FAULT_O
`ifdef IO_SEQ_STATUS_EN
    ,
    output logic [7:0] DROP_CNT_O
`endif
);

    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             pg_s;
    io_state_e        state;
    logic [CNT_W-1:0] cnt;

    io_sync2 u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (PG_VDDIO_I),
        .q   (pg_s)
    );

    // Pad controls are registered from the current state, so they
    // follow a state change by one cycle; reset still isolates at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_OFF;
            cnt      <= '0;
            RET_O    <= 1'b1;
            OE_O     <= 1'b0;
            EN_ACK_O <= 1'b0;
            FAULT_O  <= 1'b0;
        end else begin
            RET_O    <= (state == ST_OFF) || (state == ST_DEBOUNCE);
            OE_O     <= (state == ST_ON);
            EN_ACK_O <= (state == ST_ON);
            unique case (state)
                ST_OFF: begin
                    if (FAULT_O) begin
                        if (!EN_REQ_I)
                            FAULT_O <= 1'b0;
                    end else if (pg_s && EN_REQ_I) begin
                        state <= ST_DEBOUNCE;
                        cnt   <= '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!pg_s || !EN_REQ_I) begin
                        state <= ST_OFF;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!pg_s) begin
                        state <= ST_OFF;
                        cnt   <= '0;
                    end else if (!EN_REQ_I) begin
                        state <= ST_DRAIN;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= ST_ON;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (!pg_s) begin
                        state   <= ST_OFF;
                        cnt     <= '0;
                        FAULT_O <= 1'b1;
                    end else if (!EN_REQ_I) begin
                        state <= ST_DRAIN;
                        cnt   <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Late requests are ignored until the drain completes.
                    if (!pg_s || (cnt == HOLD_LAST)) begin
                        state <= ST_OFF;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef IO_SEQ_STATUS_EN
    logic pg_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pg_q       <= 1'b0;
            DROP_CNT_O <= 8'd0;
        end else begin
            pg_q <= pg_s;
            if (pg_q && !pg_s && (DROP_CNT_O != 8'hff))
                DROP_CNT_O <= DROP_CNT_O + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Self-checking bench for io_ring_pwr_seq against a cycle-level model.
// Define IO_SEQ_STATUS_EN to also check the drop counter.
module tb_io_ring_pwr_seq;

    localparam int DEB  = 4;
    localparam int HOLD = 2;

    localparam int M_OFF = 0;
    localparam int M_DEB = 1;
    localparam int M_REL = 2;
    localparam int M_ON  = 3;
    localparam int M_DRN = 4;

    logic clk = 1'b0;
    logic rst;
    logic pg;
    logic en_req;
    logic en_ack;
    logic ret;
    logic oe;
    logic fault;
`ifdef IO_SEQ_STATUS_EN
    logic [7:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    int   m_mode;
    int   m_n;
    logic m_fault;
    logic m_ret;
    logic m_on;
    logic m_f1;
    logic m_f2;
    logic m_pgq;
    int   m_drop;

    io_ring_pwr_seq #(
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HOLD)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .PG_VDDIO_I (pg),
        .EN_REQ_I   (en_req),
        .EN_ACK_O   (en_ack),
        .RET_O      (ret),
        .OE_O       (oe),
        .FAULT_O    (fault)
`ifdef IO_SEQ_STATUS_EN
        ,
        .DROP_CNT_O (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_OFF;
        m_n     = 0;
        m_fault = 1'b0;
        m_ret   = 1'b1;
        m_on    = 1'b0;
        m_f1    = 1'b0;
        m_f2    = 1'b0;
        m_pgq   = 1'b0;
        m_drop  = 0;
    endtask

    // One rising edge of the sequencer, from the written rules.
    task automatic model_step(input logic p, input logic e);
        logic s;
        s     = m_f2;
        m_ret = (m_mode == M_OFF) || (m_mode == M_DEB);
        m_on  = (m_mode == M_ON);
        if (m_pgq && !s && m_drop < 255)
            m_drop++;
        m_pgq = s;
        m_f2  = m_f1;
        m_f1  = p;
        case (m_mode)
            M_OFF: begin
                if (m_fault) begin
                    if (!e) m_fault = 1'b0;
                end else if (s && e) begin
                    m_mode = M_DEB;
                    m_n    = 0;
                end
            end
            M_DEB: begin
                if (!s || !e) m_mode = M_OFF;
                else begin
                    m_n++;
                    if (m_n == DEB) begin
                        m_mode = M_REL;
                        m_n    = 0;
                    end
                end
            end
            M_REL: begin
                if (!s) m_mode = M_OFF;
                else if (!e) begin
                    m_mode = M_DRN;
                    m_n    = 0;
                end else begin
                    m_n++;
                    if (m_n == HOLD) m_mode = M_ON;
                end
            end
            M_ON: begin
                if (!s) begin
                    m_mode  = M_OFF;
                    m_fault = 1'b1;
                end else if (!e) begin
                    m_mode = M_DRN;
                    m_n    = 0;
                end
            end
            default: begin
                if (!s) m_mode = M_OFF;
                else begin
                    m_n++;
                    if (m_n == HOLD) m_mode = M_OFF;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("ret", ret, m_ret);
        check("oe", oe, m_on);
        check("ack", en_ack, m_on);
        check("fault", fault, m_fault);
`ifdef IO_SEQ_STATUS_EN
        check("drop", drop_cnt, m_drop);
`endif
    endtask

    task automatic cyc(input logic p, input logic e);
        pg     = p;
        en_req = e;
        model_step(p, e);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int ret_at;
        int ack_at;
        logic e;
        rst    = 1'b1;
        pg     = 1'b0;
        en_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Power-up latency from the edge that samples the request.
        repeat (4) cyc(1'b1, 1'b0);
        ret_at = -1;
        ack_at = -1;
        for (int i = 0; i < 40 && ack_at < 0; i++) begin
            cyc(1'b1, 1'b1);
            if (ret_at < 0 && !ret) ret_at = i;
            if (en_ack) ack_at = i;
        end
        check("ret_fall_lat", ret_at, 5);
        check("ack_lat", ack_at, 7);
        check("oe_with_ack", oe, 1);

        // Orderly drain.
        cyc(1'b1, 1'b0);
        check("drn_oe0", oe, 1);
        cyc(1'b1, 1'b0);
        check("drn_oe1", oe, 0);
        check("drn_ret1", ret, 0);
        cyc(1'b1, 1'b0);
        check("drn_oe2", oe, 0);
        check("drn_ret2", ret, 0);
        cyc(1'b1, 1'b0);
        check("drn_off_ret", ret, 1);

        // One-cycle glitch during debounce restarts the count.
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        ack_at = -1;
        for (int i = 1; i <= 30 && ack_at < 0; i++) begin
            cyc(1'b1, 1'b1);
            if (i == 7) check("glitch_ret", ret, 1);
            if (en_ack) ack_at = i;
        end
        check("glitch_ack_lat", ack_at, 10);

        // Power loss and request drop on the same edge.
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("fault_set", fault, 1);
        repeat (12) cyc(1'b1, 1'b1);
        check("fault_block_ack", en_ack, 0);
        check("fault_held", fault, 1);
        cyc(1'b1, 1'b0);
        check("fault_clr", fault, 0);
        repeat (8) cyc(1'b1, 1'b1);
        check("refire_ack", en_ack, 1);

        // Asynchronous reset in RELEASE.
        repeat (4) cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b1, 1'b1);
        check("rel_ret", ret, 0);
        #1 rst = 1'b1;
        #1;
        check("arst_ret", ret, 1);
        check("arst_oe", oe, 0);
        check("arst_ack", en_ack, 0);
        check("arst_fault", fault, 0);
        model_reset();
        #1 rst = 1'b0;
        compare_all();

        // Random traffic.
        e = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) e = ~e;
            cyc(logic'($urandom_range(0, 19) != 0), e);
        end

`ifdef IO_SEQ_STATUS_EN
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        repeat (3) cyc(1'b1, 1'b0);
        check("drop_sat", drop_cnt, 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_ring_pwr_seq.md
IO_RING_PWR_SEQ -- requirements
Module: io_ring_pwr_seq

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 64: consecutive synchronized power-good-high cycles required before pads are released; legal range 1..1023.
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles spent in RELEASE and in DRAIN; legal range 1..1023.
REQ-003 SHALL have port CLK, in, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have port PG_VDDIO_I, in, 1: asynchronous VDDIO power-good from the IO-ring supply detector.
REQ-006 SHALL have port EN_REQ_I, in, 1: synchronous request to enable the pad ring.
REQ-007 SHALL have port EN_ACK_O, out, 1: pad ring enabled; high only in state ON.
REQ-008 SHALL have port RET_O, out, 1: pad retention/isolation; 1 = isolated.
REQ-009 SHALL have port OE_O, out, 1: global pad output-driver enable.
REQ-010 SHALL have port FAULT_O, out, 1: sticky flag for power-good loss while in ON.
REQ-011 SHALL have port DROP_CNT_O, out, 8, present only under IO_SEQ_STATUS_EN: count of power-good drops.

Function
REQ-012 SHALL synchronize PG_VDDIO_I through two flops (reset value 0) before any use; pg_s denotes the synchronized value.
REQ-013 SHALL implement a Moore FSM with states OFF, DEBOUNCE, RELEASE, ON, DRAIN; all outputs registered and decoded from state.
REQ-014 Outputs per state: OFF RET=1 OE=0 ACK=0; DEBOUNCE RET=1 OE=0 ACK=0; RELEASE RET=0 OE=0 ACK=0; ON RET=0 OE=1 ACK=1; DRAIN RET=0 OE=0 ACK=0.
REQ-015 OFF->DEBOUNCE when pg_s=1, EN_REQ_I=1 and FAULT_O=0; the cycle counter loads 0.
REQ-016 DEBOUNCE: pg_s=0 or EN_REQ_I=0 -> OFF; otherwise the counter increments and moves to RELEASE after exactly DEBOUNCE_CYC cycles in DEBOUNCE.
REQ-017 RELEASE: lasts exactly HOLD_CYC cycles, then -> ON; pg_s=0 -> OFF without fault; EN_REQ_I=0 -> DRAIN.
REQ-018 ON: pg_s=0 -> OFF and set FAULT_O in the same edge; else EN_REQ_I=0 -> DRAIN.
REQ-019 Simultaneous pg_s=0 and EN_REQ_I=0 in ON: power loss wins (OFF, FAULT_O=1).
REQ-020 DRAIN: lasts exactly HOLD_CYC cycles, then -> OFF; pg_s=0 -> OFF immediately without fault; EN_REQ_I re-asserted during DRAIN is ignored until OFF.
REQ-021 FAULT_O clears only in OFF with EN_REQ_I=0; while set it blocks OFF->DEBOUNCE, so software must drop and re-raise the request.
REQ-022 Latency with pg_s already 1: EN_ACK_O rises 1+DEBOUNCE_CYC+HOLD_CYC cycles after the edge sampling EN_REQ_I=1.
REQ-023 Counter width SHALL be $clog2(max(DEBOUNCE_CYC,HOLD_CYC)+1); no wrap is reachable.

Reset
REQ-024 RST SHALL asynchronously force state OFF, counter 0, synchronizer flops 0, RET_O=1, OE_O=0, EN_ACK_O=0, FAULT_O=0, DROP_CNT_O=0.
REQ-025 RST asserted in any state, including ON, SHALL isolate the pads (RET_O=1, OE_O=0) immediately without waiting for a clock edge.

Configuration
REQ-026 With macro IO_SEQ_STATUS_EN defined: DROP_CNT_O exists and increments on every pg_s 1->0 transition in any state, saturating at 255 and cleared only by RST.
REQ-027 Without IO_SEQ_STATUS_EN: the DROP_CNT_O port and its logic are absent, and all other behaviour is identical.

Structure
REQ-028 Package io_ring_pkg SHALL hold the state enum typedef and the default values of DEBOUNCE_CYC and HOLD_CYC.
REQ-029 The synchronizer SHALL be sub-module io_sync2, a 2-flop synchronizer with asynchronous active-high reset to 0, instantiated once.

Verification (DEBOUNCE_CYC=4, HOLD_CYC=2)
REQ-030 Reset release with PG=1, then EN_REQ=1 -> EN_ACK_O rises exactly 7 cycles after EN_REQ is sampled; RET_O falls 5 cycles after sampling; OE_O rises with EN_ACK_O.
REQ-031 PG glitches low for 1 cycle in DEBOUNCE -> FSM returns to OFF, RET_O stays 1, and the 7-cycle count restarts from the next qualifying cycle.
REQ-032 In ON, PG and EN_REQ drop on the same cycle -> OFF, FAULT_O=1; re-raising EN_REQ has no effect until EN_REQ is low for 1 cycle.
REQ-033 In ON, EN_REQ=0 -> OE_O=0 for 2 cycles with RET_O=0, then RET_O=1 in OFF.
REQ-034 RST pulse mid-RELEASE -> outputs at reset values asynchronously, FSM in OFF.
REQ-035 With IO_SEQ_STATUS_EN: 300 PG drops -> DROP_CNT_O=255.
